// File: rtl/femto_bus_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port count,
// and the port-index / one-hot grant types.
package femto_bus_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Port index (also used as the round-robin pointer) and one-hot grant vector.
    typedef logic                 port_t;
    typedef logic [NUM_PORTS-1:0] grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational, zero latency.
// A lone requester always wins; on contention ptr_i names the winner.
module rr_arbiter2
    import femto_bus_pkg::*;
(
    input  grant_t req_i,
    input  port_t  ptr_i,
    output grant_t grant_o
);

    always_comb begin
        grant_o = req_i;
        if (&req_i) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle RAM between a CPU port and a loader port.
// Fixed latency: REQ at t, MEM_EN at t+1, ACK at t+2; requests are only sampled in IDLE.
module mem_arbiter
    import femto_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req0_i,
    input  logic                req1_i,
    input  logic [DATA_W/8-1:0] wmask0_i,
    input  logic [DATA_W/8-1:0] wmask1_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   wdata0_i,
    input  logic [DATA_W-1:0]   wdata1_i,
    output logic                ack0_o,
    output logic                ack1_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_en_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    port_t               ptr_q, ptr_d;
    port_t               owner_q, owner_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    grant_t req_vec;
    grant_t grant;
    logic   in_access;
    logic   in_resp;

    assign req_vec = {req1_i, req0_i};

    rr_arbiter2 u_rr (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d = ST_ACCESS;
                    owner_d = grant[1];
                    if (grant[0]) begin
                        wmask_d = wmask0_i;
                        addr_d  = addr0_i;
                        wdata_d = wdata0_i;
                    end else begin
                        wmask_d = wmask1_i;
                        addr_d  = addr1_i;
                        wdata_d = wdata1_i;
                    end
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
                // Hand priority to the other port so neither waits behind two foreign accesses.
                ptr_d   = ~owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Reset gates the outputs immediately so an access caught mid-flight never strobes the RAM or ACKs.
    assign in_access = (state_q == ST_ACCESS) && !reset_i;
    assign in_resp   = (state_q == ST_RESP) && !reset_i;

    assign mem_en_o    = in_access;
    assign mem_wmask_o = in_access ? wmask_q : '0;
    assign mem_addr_o  = in_access ? (addr_q >> 2) : '0;
    assign mem_wdata_o = in_access ? wdata_q : '0;

    assign ack0_o  = in_resp && !owner_q;
    assign ack1_o  = in_resp && owner_q;
    assign rdata_o = in_resp ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal cases followed by random traffic,
// all cycles checked against a timestamp-based transaction model.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req0_i, req1_i;
    logic [3:0]  wmask0_i, wmask1_i;
    logic [31:0] addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic        ack0_o, ack1_o;
    logic [31:0] rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req0_i      (req0_i),
        .req1_i      (req1_i),
        .wmask0_i    (wmask0_i),
        .wmask1_i    (wmask1_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .ack0_o      (ack0_o),
        .ack1_o      (ack1_o),
        .rdata_o     (rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Model: one outstanding transaction, issued at cycle t0; it strobes the RAM
    // at t0+1 and acknowledges at t0+2. Contention goes to the preferred port,
    // and preference flips to the other port after every acknowledge.
    bit          pend     = 0;
    int          t0       = 0;
    bit          mport    = 0;
    bit          pref     = 0;
    bit          post_rst = 0;
    logic [3:0]  m_wm     = '0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wd     = '0;

    always @(negedge clk_i) begin
        bit          e_en, e_a0, e_a1;
        logic [3:0]  e_wm;
        e_en = 0; e_a0 = 0; e_a1 = 0; e_wm = '0;
        if (!reset_i && pend) begin
            if (cyc == t0 + 1) begin
                e_en = 1;
                e_wm = m_wm;
            end
            if (cyc == t0 + 2) begin
                if (mport) e_a1 = 1;
                else       e_a0 = 1;
            end
        end
        chk("mem_en", mem_en_o, e_en);
        chk("mem_wmask", mem_wmask_o, e_wm);
        chk("ack0", ack0_o, e_a0);
        chk("ack1", ack1_o, e_a1);
        chk("ack_exclusive", ack0_o & ack1_o, 0);
        if (e_en) begin
            chk("mem_addr", mem_addr_o, m_addr >> 2);
            chk("mem_wdata", mem_wdata_o, m_wd);
        end
        if ((e_a0 || e_a1) && m_wm == 4'h0)
            chk("rdata", rdata_o, mem_rdata_i);
        if (reset_i || post_rst) begin
            chk("rst_rdata", rdata_o, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            chk("rst_mem_wdata", mem_wdata_o, 0);
        end

        if (reset_i) begin
            pend = 0;
            pref = 0;
        end else if (pend && cyc == t0 + 2) begin
            pend = 0;
            pref = !mport;
        end else if (!pend && (req0_i || req1_i)) begin
            pend  = 1;
            t0    = cyc;
            mport = (req0_i && req1_i) ? pref : req1_i;
            m_wm   = mport ? wmask1_i : wmask0_i;
            m_addr = mport ? addr1_i  : addr0_i;
            m_wd   = mport ? wdata1_i : wdata0_i;
        end
        post_rst = reset_i;
        cyc++;
    end

    initial begin
        reset_i = 1; req0_i = 0; req1_i = 0;
        wmask0_i = 0; wmask1_i = 0; addr0_i = 0; addr1_i = 0;
        wdata0_i = 0; wdata1_i = 0; mem_rdata_i = 0;
        repeat (3) step();

        // Both ports hammering from reset: ACKs at 2,5,8,11 alternating 0,1,0,1.
        reset_i = 0; req0_i = 1; req1_i = 1;
        for (int k = 0; k < 12; k++) begin
            #2;
            chk("rr_ack0", ack0_o, (k == 2 || k == 8));
            chk("rr_ack1", ack1_o, (k == 5 || k == 11));
            step();
        end
        req0_i = 0; req1_i = 0;
        step();

        // Port-1 partial write.
        req1_i = 1; wmask1_i = 4'b0011; addr1_i = 32'h20; wdata1_i = 32'h12345678;
        step();
        req1_i = 0; wmask1_i = 0; addr1_i = 32'h7; wdata1_i = 32'h0;
        #2;
        chk("wr_en", mem_en_o, 1);
        chk("wr_wmask", mem_wmask_o, 4'b0011);
        chk("wr_addr", mem_addr_o, 32'h8);
        chk("wr_wdata", mem_wdata_o, 32'h12345678);
        step();
        #2;
        chk("wr_ack1", ack1_o, 1);
        chk("wr_ack0", ack0_o, 0);
        step();

        // Port-0 read with the address changing mid-access.
        req0_i = 1; addr0_i = 32'h10; wmask0_i = 0;
        step();
        req0_i = 0; addr0_i = 32'h40;
        #2;
        chk("rd_en", mem_en_o, 1);
        chk("rd_addr", mem_addr_o, 32'h4);
        step();
        mem_rdata_i = 32'hDEADBEEF;
        #2;
        chk("rd_ack0", ack0_o, 1);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        step();
        mem_rdata_i = 0;

        // Reset during ACCESS of a port-1 write; pointer was favouring port 1.
        req1_i = 1; wmask1_i = 4'hF; addr1_i = 32'h30; wdata1_i = 32'hCAFEF00D;
        step();
        req1_i = 0; reset_i = 1;
        #2;
        chk("ab_en", mem_en_o, 0);
        chk("ab_wmask", mem_wmask_o, 0);
        step();
        reset_i = 0; wmask1_i = 0; req0_i = 1; req1_i = 1;
        addr0_i = 32'h100; addr1_i = 32'h200;
        #2;
        chk("ab_ack1", ack1_o, 0);
        chk("ab_en_after", mem_en_o, 0);
        step();
        req0_i = 0; req1_i = 0;
        #2;
        chk("ab_regrant_en", mem_en_o, 1);
        chk("ab_regrant_addr", mem_addr_o, 32'h40);
        step();
        #2;
        chk("ab_regrant_ack0", ack0_o, 1);
        chk("ab_regrant_ack1", ack1_o, 0);
        step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset_i     = ($urandom_range(0, 99) == 0);
            req0_i      = 1'($urandom_range(0, 1));
            req1_i      = 1'($urandom_range(0, 1));
            wmask0_i    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            wmask1_i    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            addr0_i     = $urandom;
            addr1_i     = $urandom;
            wdata0_i    = $urandom;
            wdata1_i    = $urandom;
            mem_rdata_i = $urandom;
            step();
        end
        reset_i = 0; req0_i = 0; req1_i = 0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
